// File: rtl/cve2_sleep_ctrl_if.sv
// Handshake bundle between the CVE2 core/top level and the sleep controller.
// The master side drives requests and masks; the slave side is the controller.
interface cve2_sleep_ctrl_if #(
  parameter int NumWake       = 4,
  parameter int SleepCntWidth = 32
);
  logic                     test_en_i;
  logic                     fetch_enable_i;
  logic                     core_busy_i;
  logic [NumWake-1:0]       wake_i;
  logic [NumWake-1:0]       wake_en_i;
  logic                     irq_nm_i;
  logic                     debug_req_i;
  logic                     sleep_cnt_clr_i;
  logic                     clock_en_o;
  logic                     fetch_enable_o;
  logic                     core_sleep_o;
  logic [NumWake+1:0]       wake_cause_o;
  logic [SleepCntWidth-1:0] sleep_cycles_o;

  modport master (
    output test_en_i, fetch_enable_i, core_busy_i, wake_i, wake_en_i,
           irq_nm_i, debug_req_i, sleep_cnt_clr_i,
    input  clock_en_o, fetch_enable_o, core_sleep_o, wake_cause_o, sleep_cycles_o
  );

  modport slave (
    input  test_en_i, fetch_enable_i, core_busy_i, wake_i, wake_en_i,
           irq_nm_i, debug_req_i, sleep_cnt_clr_i,
    output clock_en_o, fetch_enable_o, core_sleep_o, wake_cause_o, sleep_cycles_o
  );
endinterface

// File: rtl/cve2_sleep_ctrl.sv
// Core clock-gate / sleep controller: sticky fetch enable, idle hold-off before
// gating, maskable plus NMI/debug wake, wake-cause capture and sleep-cycle count.

module cve2_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);
  logic en_latch;

  // Enable is captured while the clock is low so clk_o never glitches.
  always_latch begin
    if (!clk_i) begin
      en_latch = en_i | scan_cg_en_i;
    end
  end

  assign clk_o = en_latch & clk_i;
endmodule

module cve2_sleep_ctrl #(
  parameter int NumWake       = 4,
  parameter int IdleHoldoff   = 0,
  parameter int SleepCntWidth = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            clk_o,
  cve2_sleep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StDisabled,
    StActive,
    StHoldoff,
    StSleep
  } state_e;

  localparam logic [7:0] HoldInit  = (IdleHoldoff > 1) ? 8'(IdleHoldoff - 1) : 8'd0;
  localparam logic       HoldEn    = (IdleHoldoff != 0);
  localparam logic       ShortHold = (IdleHoldoff <= 1);

  state_e                   state_q, state_d;
  logic                     busy_q;
  logic [7:0]               hold_cnt_q, hold_cnt_d;
  logic [NumWake+1:0]       wake_cause_q, wake_cause_d;
  logic [SleepCntWidth-1:0] sleep_cnt_q, sleep_cnt_d;

  logic [NumWake-1:0] wake_masked;
  logic               wake_any;
  logic               act;
  logic               enabled;
  logic               clock_en;
  logic               core_sleep;

  assign wake_masked = bus.wake_i & bus.wake_en_i;
  assign wake_any    = (|wake_masked) | bus.irq_nm_i | bus.debug_req_i;
  assign act         = busy_q | wake_any;
  assign enabled     = (state_q != StDisabled);

  // Clock stays open while active, through the hold-off window, and the moment a wake rises.
  assign clock_en    = enabled & (act | (state_q == StHoldoff) | ((state_q == StActive) & HoldEn));
  assign core_sleep  = enabled & ~clock_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StDisabled;
      busy_q       <= 1'b0;
      hold_cnt_q   <= 8'd0;
      wake_cause_q <= '0;
      sleep_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= bus.core_busy_i;
      hold_cnt_q   <= hold_cnt_d;
      wake_cause_q <= wake_cause_d;
      sleep_cnt_q  <= sleep_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    wake_cause_d = wake_cause_q;
    sleep_cnt_d  = sleep_cnt_q;

    unique case (state_q)
      StDisabled: begin
        if (bus.fetch_enable_i) begin
          state_d = StActive;
        end
      end
      StActive: begin
        if (!act) begin
          if (ShortHold) begin
            state_d = StSleep;
          end else begin
            state_d    = StHoldoff;
            hold_cnt_d = HoldInit;
          end
        end
      end
      StHoldoff: begin
        if (act) begin
          state_d = StActive;
        end else if (hold_cnt_q == 8'd1) begin
          state_d = StSleep;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      StSleep: begin
        if (act) begin
          state_d      = StActive;
          wake_cause_d = {bus.debug_req_i, bus.irq_nm_i, wake_masked};
        end
      end
      default: state_d = StDisabled;
    endcase

    // Clear beats increment; the counter sticks at all-ones.
    if (bus.sleep_cnt_clr_i) begin
      sleep_cnt_d = '0;
    end else if (core_sleep && (sleep_cnt_q != {SleepCntWidth{1'b1}})) begin
      sleep_cnt_d = sleep_cnt_q + 1'b1;
    end
  end

  assign bus.clock_en_o     = clock_en;
  assign bus.fetch_enable_o = enabled;
  assign bus.core_sleep_o   = core_sleep;
  assign bus.wake_cause_o   = wake_cause_q;
  assign bus.sleep_cycles_o = sleep_cnt_q;

  cve2_clock_gate u_clock_gate (
    .clk_i        (clk_i),
    .en_i         (clock_en),
    .scan_cg_en_i (bus.test_en_i),
    .clk_o        (clk_o)
  );

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Bench for cve2_sleep_ctrl: two instances (IdleHoldoff 0 and 4) share stimulus
// and are checked every cycle against an idle-run-length model plus directed literals.
module tb_cve2_sleep_ctrl;

  logic       clk;
  logic       rstN;
  logic       testEn, fe, busy, nmi, dbg, clr;
  logic [3:0] wake, wakeEn;
  logic       clk0o, clk4o;

  int passCnt  = 0;
  int totalCnt = 0;
  int edges0   = 0;
  int edges4   = 0;

  cve2_sleep_ctrl_if #(.NumWake(4), .SleepCntWidth(4))  if0 ();
  cve2_sleep_ctrl_if #(.NumWake(4), .SleepCntWidth(32)) if4 ();

  assign if0.test_en_i = testEn;   assign if4.test_en_i = testEn;
  assign if0.fetch_enable_i = fe;  assign if4.fetch_enable_i = fe;
  assign if0.core_busy_i = busy;   assign if4.core_busy_i = busy;
  assign if0.wake_i = wake;        assign if4.wake_i = wake;
  assign if0.wake_en_i = wakeEn;   assign if4.wake_en_i = wakeEn;
  assign if0.irq_nm_i = nmi;       assign if4.irq_nm_i = nmi;
  assign if0.debug_req_i = dbg;    assign if4.debug_req_i = dbg;
  assign if0.sleep_cnt_clr_i = clr; assign if4.sleep_cnt_clr_i = clr;

  cve2_sleep_ctrl #(.NumWake(4), .IdleHoldoff(0), .SleepCntWidth(4)) dut0 (
    .clk_i(clk), .rst_ni(rstN), .clk_o(clk0o), .bus(if0.slave)
  );

  cve2_sleep_ctrl #(.NumWake(4), .IdleHoldoff(4), .SleepCntWidth(32)) dut4 (
    .clk_i(clk), .rst_ni(rstN), .clk_o(clk4o), .bus(if4.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk0o) edges0 <= edges0 + 1;
  always @(posedge clk4o) edges4 <= edges4 + 1;

  // Model: an enabled core stays clocked while active and for the first
  // IdleHoldoff idle cycles of each idle run; the run length is all we track.
  int     hold [2]   = '{0, 4};
  longint cntMax [2] = '{64'd15, 64'hFFFF_FFFF};
  bit        mEnabled [2];
  int        mIdle [2];
  logic [5:0] mCause [2];
  longint    mCnt [2];
  int        mEdges [2] = '{0, 0};
  bit        mBusyQ;

  function automatic bit actNow();
    return mBusyQ | (|(wake & wakeEn)) | nmi | dbg;
  endfunction

  function automatic int sleepAt(int k);
    return (hold[k] > 0) ? hold[k] : 1;
  endfunction

  function automatic bit expEn(int k);
    return mEnabled[k] && (actNow() || (mIdle[k] < hold[k]));
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < 2; k++) begin
        mEnabled[k] <= 1'b0;
        mIdle[k]    <= 0;
        mCause[k]   <= '0;
        mCnt[k]     <= 0;
      end
      mBusyQ <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (expEn(k) || testEn) mEdges[k] <= mEdges[k] + 1;
        if (clr) mCnt[k] <= 0;
        else if (mEnabled[k] && !expEn(k) && (mCnt[k] < cntMax[k])) mCnt[k] <= mCnt[k] + 1;
        if (mEnabled[k] && (mIdle[k] >= sleepAt(k)) && actNow())
          mCause[k] <= {dbg, nmi, wake & wakeEn};
        if (!mEnabled[k]) begin
          mEnabled[k] <= fe;
          mIdle[k]    <= 0;
        end else if (actNow()) begin
          mIdle[k] <= 0;
        end else if (mIdle[k] < sleepAt(k)) begin
          mIdle[k] <= mIdle[k] + 1;
        end
      end
      mBusyQ <= busy;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    totalCnt++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    else
      passCnt++;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    checkOutput("c0.clock_en",   64'(if0.clock_en_o),     64'(expEn(0)));
    checkOutput("c0.core_sleep", 64'(if0.core_sleep_o),   64'(mEnabled[0] && !expEn(0)));
    checkOutput("c0.fetch_en",   64'(if0.fetch_enable_o), 64'(mEnabled[0]));
    checkOutput("c0.wake_cause", 64'(if0.wake_cause_o),   64'(mCause[0]));
    checkOutput("c0.sleep_cnt",  64'(if0.sleep_cycles_o), 64'(mCnt[0]));
    checkOutput("c0.clk_edges",  64'(edges0),             64'(mEdges[0]));
    checkOutput("c4.clock_en",   64'(if4.clock_en_o),     64'(expEn(1)));
    checkOutput("c4.core_sleep", 64'(if4.core_sleep_o),   64'(mEnabled[1] && !expEn(1)));
    checkOutput("c4.fetch_en",   64'(if4.fetch_enable_o), 64'(mEnabled[1]));
    checkOutput("c4.wake_cause", 64'(if4.wake_cause_o),   64'(mCause[1]));
    checkOutput("c4.sleep_cnt",  64'(if4.sleep_cycles_o), 64'(mCnt[1]));
    checkOutput("c4.clk_edges",  64'(edges4),             64'(mEdges[1]));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int e0, e4;

  initial begin
    rstN = 1'b0; testEn = 1'b0; fe = 1'b0; busy = 1'b1;
    nmi = 1'b0; dbg = 1'b0; clr = 1'b0; wake = 4'b0000; wakeEn = 4'b0101;

    applyStimulus(3);
    rstN = 1'b1;
    applyStimulus(3);
    @(negedge clk);
    checkOutput("lit.reset_fetch0", 64'(if0.fetch_enable_o), 64'd0);
    checkOutput("lit.reset_en0",    64'(if0.clock_en_o),     64'd0);
    checkOutput("lit.reset_sleep0", 64'(if0.core_sleep_o),   64'd0);
    checkOutput("lit.reset_en4",    64'(if4.clock_en_o),     64'd0);
    checkOutput("lit.no_edges0",    64'(edges0),             64'd0);
    checkOutput("lit.no_edges4",    64'(edges4),             64'd0);

    applyStimulus(1);
    fe = 1'b1;
    applyStimulus(1);
    fe = 1'b0;
    @(negedge clk);
    checkOutput("lit.fetch_on0", 64'(if0.fetch_enable_o), 64'd1);
    checkOutput("lit.en_on0",    64'(if0.clock_en_o),     64'd1);
    checkOutput("lit.fetch_on4", 64'(if4.fetch_enable_o), 64'd1);
    checkOutput("lit.en_on4",    64'(if4.clock_en_o),     64'd1);

    // Drop busy at T: gating (holdoff 0) starts at T+1.
    applyStimulus(3);
    busy = 1'b0;
    @(negedge clk);
    checkOutput("lit.en_T0", 64'(if0.clock_en_o), 64'd1);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("lit.gate_T1_en0",    64'(if0.clock_en_o),   64'd0);
    checkOutput("lit.gate_T1_sleep0", 64'(if0.core_sleep_o), 64'd1);
    checkOutput("lit.hold_T1_en4",    64'(if4.clock_en_o),   64'd1);
    e4 = edges4;
    applyStimulus(8);
    @(negedge clk);
    checkOutput("lit.hold4_edges", 64'(edges4 - e4),        64'd4);
    checkOutput("lit.hold4_sleep", 64'(if4.core_sleep_o),   64'd1);
    applyStimulus(12);
    @(negedge clk);
    checkOutput("lit.cnt_sat", 64'(if0.sleep_cycles_o), 64'd15);

    applyStimulus(1);
    clr = 1'b1;
    applyStimulus(1);
    clr = 1'b0;
    @(negedge clk);
    checkOutput("lit.cnt_clr0", 64'(if0.sleep_cycles_o), 64'd0);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("lit.cnt_clr1", 64'(if0.sleep_cycles_o), 64'd1);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("lit.cnt_clr2", 64'(if0.sleep_cycles_o), 64'd2);

    // Masked source must not wake; enabled source wakes in the same cycle.
    applyStimulus(1);
    wake = 4'b0010;
    @(negedge clk);
    checkOutput("lit.masked_en0",    64'(if0.clock_en_o),   64'd0);
    checkOutput("lit.masked_sleep0", 64'(if0.core_sleep_o), 64'd1);
    checkOutput("lit.masked_en4",    64'(if4.clock_en_o),   64'd0);
    applyStimulus(2);
    wake = 4'b0100;
    @(negedge clk);
    checkOutput("lit.wake_en0", 64'(if0.clock_en_o), 64'd1);
    checkOutput("lit.wake_en4", 64'(if4.clock_en_o), 64'd1);
    applyStimulus(1);
    wake = 4'b0000;
    @(negedge clk);
    checkOutput("lit.cause_wake0", 64'(if0.wake_cause_o), 64'h04);
    checkOutput("lit.cause_wake4", 64'(if4.wake_cause_o), 64'h04);
    checkOutput("lit.regate_en0",  64'(if0.clock_en_o),   64'd0);

    applyStimulus(10);
    dbg = 1'b1;
    @(negedge clk);
    checkOutput("lit.dbg_en0", 64'(if0.clock_en_o), 64'd1);
    checkOutput("lit.dbg_en4", 64'(if4.clock_en_o), 64'd1);
    applyStimulus(1);
    dbg = 1'b0;
    @(negedge clk);
    checkOutput("lit.cause_dbg0", 64'(if0.wake_cause_o), 64'h20);
    checkOutput("lit.cause_dbg4", 64'(if4.wake_cause_o), 64'h20);

    applyStimulus(10);
    nmi = 1'b1;
    applyStimulus(1);
    nmi = 1'b0;
    @(negedge clk);
    checkOutput("lit.cause_nmi0", 64'(if0.wake_cause_o), 64'h10);

    // Busy-only wake latches an all-zero cause.
    applyStimulus(10);
    busy = 1'b1;
    applyStimulus(1);
    busy = 1'b0;
    @(negedge clk);
    checkOutput("lit.busy_wake_en0", 64'(if0.clock_en_o), 64'd1);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("lit.cause_busy0", 64'(if0.wake_cause_o), 64'h00);
    checkOutput("lit.cause_busy4", 64'(if4.wake_cause_o), 64'h00);

    // Scan enable opens the gate without touching the FSM.
    applyStimulus(10);
    @(negedge clk);
    e0 = edges0;
    checkOutput("lit.pre_scan_sleep0", 64'(if0.core_sleep_o), 64'd1);
    applyStimulus(1);
    testEn = 1'b1;
    applyStimulus(3);
    testEn = 1'b0;
    @(negedge clk);
    checkOutput("lit.scan_edges0", 64'(edges0 - e0),       64'd3);
    checkOutput("lit.scan_sleep0", 64'(if0.core_sleep_o),  64'd1);
    checkOutput("lit.scan_en0",    64'(if0.clock_en_o),    64'd0);

    // Busy returns when the hold-off counter reads 2: no gating on dut4.
    applyStimulus(1);
    busy = 1'b1;
    applyStimulus(2);
    busy = 1'b0;
    applyStimulus(2);
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("lit.reenter_sleep4", 64'(if4.core_sleep_o), 64'd0);
      checkOutput("lit.reenter_en4",    64'(if4.clock_en_o),   64'd1);
      applyStimulus(1);
    end

    // Reset while dut4 sits in hold-off.
    busy = 1'b0;
    applyStimulus(3);
    @(negedge clk);
    checkOutput("lit.holdoff_en4", 64'(if4.clock_en_o), 64'd1);
    applyStimulus(1);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("lit.rst_fetch4", 64'(if4.fetch_enable_o), 64'd0);
    checkOutput("lit.rst_en4",    64'(if4.clock_en_o),     64'd0);
    checkOutput("lit.rst_sleep4", 64'(if4.core_sleep_o),   64'd0);
    checkOutput("lit.rst_cnt0",   64'(if0.sleep_cycles_o), 64'd0);
    checkOutput("lit.rst_cnt4",   64'(if4.sleep_cycles_o), 64'd0);
    applyStimulus(1);
    rstN = 1'b1;
    busy = 1'b1;
    applyStimulus(3);
    @(negedge clk);
    checkOutput("lit.post_rst_fetch4", 64'(if4.fetch_enable_o), 64'd0);
    checkOutput("lit.post_rst_en4",    64'(if4.clock_en_o),     64'd0);
    applyStimulus(1);
    fe = 1'b1;
    applyStimulus(1);
    fe = 1'b0;
    @(negedge clk);
    checkOutput("lit.refetch4", 64'(if4.fetch_enable_o), 64'd1);
    applyStimulus(2);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
